// File: rtl/sram_bw_clr.sv
// Single-clock SRAM with separate write/read ports, byte enables, 1- or 2-cycle read latency
// and a built-in clear sequencer that fills the array after reset or on request.
module sram_bw_clr #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2**ADDR_W,
    parameter int                RD_LAT   = 1,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  CS,
    input  logic                  WE,
    input  logic [ADDR_W-1:0]     WrAddr,
    input  logic [DATA_W/8-1:0]   WrBe,
    input  logic [DATA_W-1:0]     dataIn,
    input  logic                  RD,
    input  logic [ADDR_W-1:0]     RdAddr,
    input  logic                  ClrReq,
    output logic [DATA_W-1:0]     dataOut,
    output logic                  RdValid,
    output logic                  Busy
);

    localparam int                BE_W     = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clrPtr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wrAcc;
    logic              rdAcc;
    logic              wrInRange;
    logic              rdInRange;
    logic              collide;
    logic [DATA_W-1:0] rdWord;

    assign Busy      = (state == CLEAR);
    assign wrAcc     = CS & WE & ~Busy;
    assign rdAcc     = CS & RD & ~Busy;
    assign wrInRange = ({1'b0, WrAddr} < DEPTH_L);
    assign rdInRange = ({1'b0, RdAddr} < DEPTH_L);
    assign collide   = wrAcc & wrInRange & (WrAddr == RdAddr);

    // Clear sequencer: walks the pointer once over the array, then hands over to normal operation.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= CLEAR;
            clrPtr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clrPtr == LAST_PTR) begin
                        state  <= RUN;
                        clrPtr <= '0;
                    end else begin
                        clrPtr <= clrPtr + 1'b1;
                    end
                end
                RUN: begin
                    if (ClrReq) begin
                        state  <= CLEAR;
                        clrPtr <= '0;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    clrPtr <= '0;
                end
            endcase
        end
    end

    // The array itself has no reset; the clear sequence is the only way to initialise it.
    always_ff @(posedge Clk) begin
        if (state == CLEAR) begin
            mem[clrPtr] <= CLR_VAL;
        end else if (wrAcc && wrInRange) begin
            for (int i = 0; i < BE_W; i++) begin
                if (WrBe[i]) begin
                    mem[WrAddr][8*i +: 8] <= dataIn[8*i +: 8];
                end
            end
        end
    end

    // Out-of-range reads return zero; in new-data mode a same-address write is merged lane by lane.
    always_comb begin
        rdWord = '0;
        if (rdInRange) begin
            rdWord = mem[RdAddr];
            if (RDW_MODE == 1 && collide) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (WrBe[i]) begin
                        rdWord[8*i +: 8] = dataIn[8*i +: 8];
                    end
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              p1Valid;
            logic [DATA_W-1:0] p1Data;

            // Reads already in the pipeline complete even if a clear starts behind them.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    p1Valid <= 1'b0;
                    p1Data  <= '0;
                    RdValid <= 1'b0;
                    dataOut <= '0;
                end else begin
                    p1Valid <= rdAcc;
                    if (rdAcc) begin
                        p1Data <= rdWord;
                    end
                    RdValid <= p1Valid;
                    if (p1Valid) begin
                        dataOut <= p1Data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    RdValid <= 1'b0;
                    dataOut <= '0;
                end else begin
                    RdValid <= rdAcc;
                    if (rdAcc) begin
                        dataOut <= rdWord;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_bw_clr.sv
// Scoreboard bench for sram_bw_clr: three instances (latency/collision-mode/depth variants)
// share one stimulus stream; a negedge monitor pops expected read results as RdValid appears.
module tb_sram_bw_clr;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        Clk    = 1'b0;
    logic        Rst_n  = 1'b0;
    logic        CS     = 1'b0;
    logic        WE     = 1'b0;
    logic        RD     = 1'b0;
    logic        ClrReq = 1'b0;
    logic [3:0]  WrAddr = '0;
    logic [3:0]  RdAddr = '0;
    logic [1:0]  WrBe   = '0;
    logic [15:0] dataIn = '0;

    logic [15:0] dA, dB, dC;
    logic        vA, vB, vC;
    logic        bA, bB, bC;

    int   edgeCnt = 0;
    int   nChecks = 0;
    int   nFails  = 0;
    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) edgeCnt <= edgeCnt + 1;

    sram_bw_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0), .CLR_VAL(16'h0000)) dutA (
        .Clk(Clk), .Rst_n(Rst_n), .CS(CS), .WE(WE), .WrAddr(WrAddr), .WrBe(WrBe), .dataIn(dataIn),
        .RD(RD), .RdAddr(RdAddr), .ClrReq(ClrReq), .dataOut(dA), .RdValid(vA), .Busy(bA));

    sram_bw_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_LAT(2), .RDW_MODE(1), .CLR_VAL(16'h0000)) dutB (
        .Clk(Clk), .Rst_n(Rst_n), .CS(CS), .WE(WE), .WrAddr(WrAddr), .WrBe(WrBe), .dataIn(dataIn),
        .RD(RD), .RdAddr(RdAddr), .ClrReq(ClrReq), .dataOut(dB), .RdValid(vB), .Busy(bB));

    sram_bw_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RD_LAT(1), .RDW_MODE(1), .CLR_VAL(16'h0000)) dutC (
        .Clk(Clk), .Rst_n(Rst_n), .CS(CS), .WE(WE), .WrAddr(WrAddr), .WrBe(WrBe), .dataIn(dataIn),
        .RD(RD), .RdAddr(RdAddr), .ClrReq(ClrReq), .dataOut(dC), .RdValid(vC), .Busy(bC));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of requests and records the read result each instance owes, with its due edge.
    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [1:0] be,
                                 input logic [15:0] din, input logic rd, input logic [3:0] ra,
                                 input logic clr, input logic [2:0] push,
                                 input logic [15:0] eA, input logic [15:0] eB, input logic [15:0] eC);
        int e1;
        CS = we | rd;  WE = we;  WrAddr = wa;  WrBe = be;  dataIn = din;
        RD = rd;  RdAddr = ra;  ClrReq = clr;
        e1 = edgeCnt + 1;
        if (push[0]) qA.push_back('{eA, e1});
        if (push[1]) qB.push_back('{eB, e1 + 1});
        if (push[2]) qC.push_back('{eC, e1});
        @(posedge Clk);
        #1;
        CS = 1'b0;  WE = 1'b0;  RD = 1'b0;  ClrReq = 1'b0;  WrBe = '0;
    endtask

    task automatic doWrite(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
        applyStimulus(1'b1, a, be, d, 1'b0, 4'd0, 1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic doRead(input logic [3:0] a, input logic [15:0] eA, input logic [15:0] eB, input logic [15:0] eC);
        applyStimulus(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, a, 1'b0, 3'b111, eA, eB, eC);
    endtask

    task automatic checkReset();
        checkOutput("rst dataOut A", 32'(dA), 32'h0);
        checkOutput("rst dataOut B", 32'(dB), 32'h0);
        checkOutput("rst dataOut C", 32'(dC), 32'h0);
        checkOutput("rst RdValid A", 32'(vA), 32'h0);
        checkOutput("rst RdValid B", 32'(vB), 32'h0);
        checkOutput("rst RdValid C", 32'(vC), 32'h0);
        checkOutput("rst Busy A", 32'(bA), 32'h1);
        checkOutput("rst Busy B", 32'(bB), 32'h1);
        checkOutput("rst Busy C", 32'(bC), 32'h1);
    endtask

    // Counts edges until each instance drops Busy; start accounts for edges already spent busy.
    task automatic countBusy(input int start, input int eA, input int eB, input int eC);
        int n  = start;
        int cA = -1;
        int cB = -1;
        int cC = -1;
        for (int k = 0; k < 64 && (cA < 0 || cB < 0 || cC < 0); k++) begin
            @(posedge Clk);
            #1;
            n++;
            if (cA < 0 && !bA) cA = n;
            if (cB < 0 && !bB) cB = n;
            if (cC < 0 && !bC) cC = n;
        end
        checkOutput("busy length A", 32'(cA), 32'(eA));
        checkOutput("busy length B", 32'(cB), 32'(eB));
        checkOutput("busy length C", 32'(cC), 32'(eC));
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (vA) begin
            if (qA.size() == 0) checkOutput("unexpected RdValid A", 32'(vA), 32'h0);
            else begin
                e = qA.pop_front();
                checkOutput("read data A", 32'(dA), 32'(e.data));
                checkOutput("read edge A", 32'(edgeCnt), 32'(e.cyc));
            end
        end
        if (vB) begin
            if (qB.size() == 0) checkOutput("unexpected RdValid B", 32'(vB), 32'h0);
            else begin
                e = qB.pop_front();
                checkOutput("read data B", 32'(dB), 32'(e.data));
                checkOutput("read edge B", 32'(edgeCnt), 32'(e.cyc));
            end
        end
        if (vC) begin
            if (qC.size() == 0) checkOutput("unexpected RdValid C", 32'(vC), 32'h0);
            else begin
                e = qC.pop_front();
                checkOutput("read data C", 32'(dC), 32'(e.data));
                checkOutput("read edge C", 32'(edgeCnt), 32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, nChecks=%0d", nChecks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        checkReset();
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        countBusy(0, 16, 16, 12);

        for (int a = 0; a < 16; a++) doRead(4'(a), 16'h0000, 16'h0000, 16'h0000);

        doWrite(4'd3, 2'b11, 16'hA5A5);
        doWrite(4'd3, 2'b01, 16'h0012);
        doRead(4'd3, 16'hA512, 16'hA512, 16'hA512);
        doWrite(4'd3, 2'b00, 16'hFFFF);
        doRead(4'd3, 16'hA512, 16'hA512, 16'hA512);

        doWrite(4'd5, 2'b11, 16'hBEEF);
        applyStimulus(1'b1, 4'd5, 2'b11, 16'h1234, 1'b1, 4'd5, 1'b0, 3'b111, 16'hBEEF, 16'h1234, 16'h1234);
        doRead(4'd5, 16'h1234, 16'h1234, 16'h1234);
        applyStimulus(1'b1, 4'd6, 2'b10, 16'hABCD, 1'b1, 4'd6, 1'b0, 3'b111, 16'h0000, 16'hAB00, 16'hAB00);
        doRead(4'd6, 16'hAB00, 16'hAB00, 16'hAB00);

        doWrite(4'd13, 2'b11, 16'h7777);
        doRead(4'd13, 16'h7777, 16'h7777, 16'h0000);

        doWrite(4'd0, 2'b11, 16'h0100);
        doWrite(4'd1, 2'b11, 16'h0101);
        doWrite(4'd2, 2'b11, 16'h0102);
        doRead(4'd0, 16'h0100, 16'h0100, 16'h0100);
        doRead(4'd1, 16'h0101, 16'h0101, 16'h0101);
        doRead(4'd2, 16'h0102, 16'h0102, 16'h0102);
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("hold dataOut A", 32'(dA), 32'h0102);
        checkOutput("hold dataOut B", 32'(dB), 32'h0102);
        checkOutput("hold dataOut C", 32'(dC), 32'h0102);

        for (int a = 0; a < 16; a++) doWrite(4'(a), 2'b11, 16'hFFFF);
        applyStimulus(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1, 3'b000, 16'h0, 16'h0, 16'h0);
        checkOutput("clr Busy A", 32'(bA), 32'h1);
        checkOutput("clr Busy B", 32'(bB), 32'h1);
        checkOutput("clr Busy C", 32'(bC), 32'h1);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 4'd0, 2'b11, 16'h5555, 1'b1, 4'd0, 1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
        countBusy(3, 16, 16, 12);
        for (int a = 0; a < 16; a++) doRead(4'(a), 16'h0000, 16'h0000, 16'h0000);

        doWrite(4'd9, 2'b11, 16'h4242);
        applyStimulus(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd9, 1'b1, 3'b101, 16'h4242, 16'h0, 16'h4242);
        @(negedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        checkReset();
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        repeat (7) @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        checkReset();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        countBusy(0, 16, 16, 12);

        repeat (4) @(posedge Clk);
        #1;
        checkOutput("pending reads A", 32'(qA.size()), 32'h0);
        checkOutput("pending reads B", 32'(qB.size()), 32'h0);
        checkOutput("pending reads C", 32'(qC.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
